// File: rtl/nes_pkg.sv
// Shared NES cartridge definitions: loader flag-word layout, iNES constants and
// the dumper state encoding.
package nes_pkg;

  localparam int MAPPER_LSB      = 0;
  localparam int PRG_SIZE_LSB    = 8;
  localparam int CHR_SIZE_LSB    = 11;
  localparam int MIRROR_BIT      = 14;
  localparam int CHR_RAM_BIT     = 15;
  localparam int FOUR_SCREEN_BIT = 16;

  // "NES" followed by MS-DOS EOF, most significant byte first
  localparam logic [31:0] INES_MAGIC       = 32'h4E45_531A;
  localparam logic [21:0] CHR_BASE_DEFAULT = 22'h200000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } dump_state_t;

  typedef struct packed {
    logic [7:0] mapper;
    logic [2:0] prg_size;
    logic [2:0] chr_size;
    logic       mirroring;
    logic       chr_ram;
    logic       four_screen;
  } ines_flags_t;

  function automatic logic [21:0] prg_bytes(input logic [2:0] sz);
    return 22'd1 << (5'd14 + 5'(sz));
  endfunction

  function automatic logic [21:0] chr_bytes(input logic ram, input logic [2:0] sz);
    return ram ? 22'd0 : 22'd1 << (5'd13 + 5'(sz));
  endfunction

endpackage

// File: rtl/ines_dumper_if.sv
// SDRAM read port plus byte-stream upload channel of the iNES dumper.
interface ines_dumper_if;
  logic [21:0] mem_addr;
  logic        mem_read;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_addr, mem_read, out_data, out_valid,
    input  mem_ack, mem_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_read, out_data, out_valid,
    output mem_ack, mem_data, out_ready
  );
endinterface

// File: rtl/ines_header_gen.sv
// Combinational iNES 1.0 header byte for a given index, rebuilt from the
// latched loader flags.
module ines_header_gen
  import nes_pkg::*;
(
  input  ines_flags_t flags,
  input  logic [3:0]  idx,
  output logic [7:0]  data
);
  always_comb begin
    data = 8'h00;
    case (idx)
      4'd0: data = INES_MAGIC[31:24];
      4'd1: data = INES_MAGIC[23:16];
      4'd2: data = INES_MAGIC[15:8];
      4'd3: data = INES_MAGIC[7:0];
      4'd4: data = 8'h01 << flags.prg_size;
      4'd5: data = flags.chr_ram ? 8'h00 : 8'h01 << flags.chr_size;
      // no trainer, no battery
      4'd6: data = {flags.mapper[3:0], flags.four_screen, 2'b00, flags.mirroring};
      4'd7: data = {flags.mapper[7:4], 4'h0};
      default: data = 8'h00;
    endcase
  end
endmodule

// File: rtl/ines_dumper.sv
// Streams the loaded cartridge back out of SDRAM as an iNES image:
// rebuilt 16-byte header, then PRG ROM, then CHR ROM.
module ines_dumper
  import nes_pkg::*;
#(
  parameter logic [21:0] CHR_BASE = CHR_BASE_DEFAULT,
  parameter logic [21:0] PRG_BASE = 22'h000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   mapper_flags,
  ines_dumper_if.master bus,
  output logic [21:0]   total_len,
  output logic          busy,
  output logic          done
);
  dump_state_t state;
  ines_flags_t flags, new_flags;
  logic [3:0]  hdr_idx, hdr_nidx;
  logic [7:0]  hdr_byte;
  logic        phase_chr;
  logic [21:0] addr, remaining, prg_len, chr_len;
  logic [21:0] mem_addr_r;
  logic        mem_read_r, out_valid_r;
  logic [7:0]  out_data_r;
  logic        unused_flags;

  assign new_flags = '{
    mapper:      mapper_flags[MAPPER_LSB +: 8],
    prg_size:    mapper_flags[PRG_SIZE_LSB +: 3],
    chr_size:    mapper_flags[CHR_SIZE_LSB +: 3],
    mirroring:   mapper_flags[MIRROR_BIT],
    chr_ram:     mapper_flags[CHR_RAM_BIT],
    four_screen: mapper_flags[FOUR_SCREEN_BIT]
  };
  assign unused_flags = ^mapper_flags[31:17];

  assign prg_len   = prg_bytes(flags.prg_size);
  assign chr_len   = chr_bytes(flags.chr_ram, flags.chr_size);
  assign total_len = 22'd16 + prg_len + chr_len;
  assign busy      = !(state == S_IDLE || state == S_DONE);
  assign done      = (state == S_DONE);

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;

  // Generator looks one byte ahead so out_data is registered. Byte 0 is flag
  // independent, so the stale flags seen on the start cycle are harmless.
  assign hdr_nidx = (state == S_HDR) ? hdr_idx + 4'd1 : 4'd0;

  ines_header_gen u_hdr (
    .flags (flags),
    .idx   (hdr_nidx),
    .data  (hdr_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      flags       <= '0;
      hdr_idx     <= '0;
      phase_chr   <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      mem_addr_r  <= '0;
      mem_read_r  <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          flags       <= new_flags;
          hdr_idx     <= 4'd0;
          out_data_r  <= hdr_byte;
          out_valid_r <= 1'b1;
          state       <= S_HDR;
        end
        S_HDR: if (bus.out_ready) begin
          if (hdr_idx == 4'd15) begin
            out_valid_r <= 1'b0;
            phase_chr   <= 1'b0;
            addr        <= PRG_BASE;
            remaining   <= prg_len;
            state       <= S_FETCH;
          end else begin
            hdr_idx    <= hdr_nidx;
            out_data_r <= hdr_byte;
          end
        end
        S_FETCH: begin
          if (remaining == '0) begin
            if (!phase_chr && chr_len != '0) begin
              phase_chr <= 1'b1;
              addr      <= CHR_BASE;
              remaining <= chr_len;
            end else begin
              state <= S_DONE;
            end
          end else begin
            mem_read_r <= 1'b1;
            mem_addr_r <= addr;
            state      <= S_WAIT;
          end
        end
        S_WAIT: if (bus.mem_ack) begin
          out_data_r  <= bus.mem_data;
          out_valid_r <= 1'b1;
          mem_read_r  <= 1'b0;
          state       <= S_EMIT;
        end
        S_EMIT: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          addr        <= addr + 22'd1;
          remaining   <= remaining - 22'd1;
          state       <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ines_dumper.sv
// Random-stall / random-latency bench for ines_dumper against a queue model of
// the expected iNES stream built from the flag word.
module tb_ines_dumper;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mapper_flags = '0;
  logic [21:0] total_len;
  logic        busy, done;

  ines_dumper_if bus ();

  ines_dumper dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mapper_flags (mapper_flags),
    .bus          (bus),
    .total_len    (total_len),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  exp_q[$];
  int          exp_len;
  int          lat_min = 1, lat_max = 1;
  logic [21:0] addr_lim = 22'h3FFFFF;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // SDRAM content model; bit 7 tracks addr[21] so PRG and CHR bytes differ
  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {a[21:16], 2'b00};
  endfunction

  // memory responder: ack after lat cycles, regardless of what the DUT did meanwhile
  initial begin
    int lat;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_read) begin
        lat = $urandom_range(lat_min, lat_max);
        repeat (lat - 1) @(negedge clk);
        if (bus.mem_read) chk("rd_addr_lim", 32'(bus.mem_addr < addr_lim), 1);
        bus.mem_data = mem_byte(bus.mem_addr);
        bus.mem_ack  = 1'b1;
      end
    end
  end

  task automatic build_exp(input logic [31:0] f, input int max_rom);
    int prg, chr, n;
    logic [7:0] m;
    logic [2:0] ps, cs;
    exp_q.delete();
    m  = f[7:0];
    ps = f[10:8];
    cs = f[13:11];
    prg = 1 << (ps + 14);
    chr = f[15] ? 0 : 1 << (cs + 13);
    exp_len = 16 + prg + chr;
    exp_q.push_back(8'h4E); exp_q.push_back(8'h45);
    exp_q.push_back(8'h53); exp_q.push_back(8'h1A);
    exp_q.push_back(8'(1 << ps));
    exp_q.push_back(f[15] ? 8'h00 : 8'(1 << cs));
    exp_q.push_back({m[3:0], f[16], 2'b00, f[14]});
    exp_q.push_back({m[7:4], 4'h0});
    repeat (8) exp_q.push_back(8'h00);
    n = 0;
    for (int i = 0; i < prg && n < max_rom; i++) begin
      exp_q.push_back(mem_byte(22'(i)));
      n++;
    end
    for (int i = 0; i < chr && n < max_rom; i++) begin
      exp_q.push_back(mem_byte(22'h200000 + 22'(i)));
      n++;
    end
  endtask

  task automatic do_start(input logic [31:0] f);
    @(negedge clk);
    bus.out_ready = 1'b0;
    mapper_flags  = f;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_valid", bus.out_valid, 1);
    chk("hdr0", bus.out_data, 8'h4E);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("total_len", total_len, exp_len);
  endtask

  task automatic run_stream(input int n, input bit stall, input bit pulse);
    logic [7:0] held = '0;
    bit hold = 1'b0;
    int got = 0, cyc = 0;
    int budget;
    budget = stall ? n * 40 + 200 : n * 4 + 200;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, held);
      end
      // a start while a byte is offered lands in HDR or EMIT and must be ignored
      start = pulse && bus.out_valid && ($urandom_range(0, 7) == 0);
      bus.out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      hold = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) chk("stream", bus.out_data, exp_q.pop_front());
        got++;
      end
    end
    start = 1'b0;
    chk("stream_count", got, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic reset_in_wait();
    int cyc;
    lat_min = 8;
    lat_max = 8;
    bus.out_ready = 1'b1;
    for (cyc = 0; cyc < 50 && bus.mem_read; cyc++) @(negedge clk);
    for (cyc = 0; cyc < 50 && !bus.mem_read; cyc++) @(negedge clk);
    chk("wait_seen", bus.mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_read", bus.mem_read, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    // the abandoned read is acked late inside this window
    repeat (10) begin
      @(negedge clk);
      chk("late_ack_read", bus.mem_read, 0);
      chk("late_ack_valid", bus.out_valid, 0);
    end
    lat_min = 1;
    lat_max = 8;
  endtask

  initial begin
    logic [31:0] f;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_total_len", total_len, 24592);
    reset = 1'b0;

    // mapper 1, prg 3, chr 4, vertical mirroring; junk in unused high bits
    lat_min = 1; lat_max = 8;
    f = 32'h0000_6301 | ($urandom() & 32'hFFFE_0000);
    build_exp(f, 150);
    do_start(f);
    chk("t1_total_len", total_len, 262160);
    run_stream(166, 1'b1, 1'b1);
    reset_in_wait();

    // mapper E4, max PRG and CHR, four-screen
    f = 32'h0001_3FE4;
    build_exp(f, 40);
    do_start(f);
    chk("t3_total_len", total_len, 3145744);
    run_stream(56, 1'b1, 1'b0);
    pulse_reset();

    // CHR RAM, smallest PRG: no CHR reads allowed
    f = 32'h0000_8000 | (32'($urandom_range(0, 7)) << 11) | 32'($urandom_range(0, 255));
    addr_lim = 22'h200000;
    build_exp(f, 40);
    do_start(f);
    chk("t2_total_len", total_len, 16400);
    run_stream(56, 1'b1, 1'b0);
    pulse_reset();
    addr_lim = 22'h3FFFFF;

    // full image: 16K PRG + 8K CHR, fast sink and 1-cycle ack
    lat_min = 1; lat_max = 1;
    f = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 1)) << 14);
    build_exp(f, 32'h7FFF_FFFF);
    do_start(f);
    run_stream(16 + 24576, 1'b0, 1'b0);
    @(negedge clk);
    chk("fetch_done", done, 0);
    chk("fetch_busy", busy, 1);
    @(negedge clk);
    chk("done_hi", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", bus.out_valid, 0);
    chk("done_read", bus.mem_read, 0);

    // restart straight from DONE
    f = 32'h0000_0A42;
    build_exp(f, 0);
    do_start(f);
    run_stream(16, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
